// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the in-order pipeline
//   write-back path and an out-of-order multiply/divide unit (MDU).
//   MDU results are buffered in a small FIFO and drained into idle write
//   slots. A starvation counter forces a drain, stalling the pipeline write,
//   once the FIFO has waited STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   pipe_we/rd/wdata     pipeline write-back request
//   pipe_stall           pipeline must hold its request (combinational)
//   mdu_valid/rd/wdata   MDU result
//   mdu_ready            FIFO not full (combinational)
//   rf_we/waddr/wdata    registered register-file write port
//   mdu_pending          bit i set while any buffered result targets x<i>
module wb_port_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    output logic            pipe_stall,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_wdata,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     mdu_pending
);

    localparam int unsigned IW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      ent_rd_q   [FIFO_DEPTH];
    logic [4:0]      ent_rd_d   [FIFO_DEPTH];
    logic [XLEN-1:0] ent_data_q [FIFO_DEPTH];
    logic [XLEN-1:0] ent_data_d [FIFO_DEPTH];
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic            empty, full, push;
    logic            pipe_req, fifo_req, forced;
    logic            grant_fifo, grant_pipe;
    logic [IW-1:0]   head_idx, wr_idx, off;
    logic [PW-1:0]   count;

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                     (wr_ptr_q[IW] != rd_ptr_q[IW]);
        mdu_ready  = !full;
        push       = mdu_valid && !full;
        pipe_req   = pipe_we && (pipe_rd != 5'd0);
        fifo_req   = !empty;
        forced     = fifo_req && (starve_cnt_q == SW'(STARVE_LIMIT));
        grant_fifo = forced || (fifo_req && !pipe_req);
        grant_pipe = pipe_req && !forced;
        pipe_stall = forced && pipe_req;
        head_idx   = rd_ptr_q[IW-1:0];
        wr_idx     = wr_ptr_q[IW-1:0];
        count      = wr_ptr_q - rd_ptr_q;
    end

    // Pending mask: an entry is live when its distance from the head is
    // below the occupancy; x0 never needs tracking.
    always_comb begin
        mdu_pending = '0;
        off         = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            off = IW'(i) - head_idx;
            if (PW'(off) < count) begin
                mdu_pending[ent_rd_q[i]] = 1'b1;
            end
        end
        mdu_pending[0] = 1'b0;
    end

    always_comb begin
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            ent_rd_d[wr_idx]   = mdu_rd;
            ent_data_d[wr_idx] = mdu_wdata;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (grant_fifo) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // A head entry targeting x0 still consumes the slot but writes nothing.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_fifo) begin
            rf_we_d    = (ent_rd_q[head_idx] != 5'd0);
            rf_waddr_d = ent_rd_q[head_idx];
            rf_wdata_d = ent_data_q[head_idx];
        end else if (grant_pipe) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_wdata;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_fifo || empty) begin
            starve_cnt_d = '0;
        end else if (grant_pipe && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            ent_rd_q     <= ent_rd_d;
            ent_data_q   <= ent_data_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter at default parameters
//   (XLEN=64, FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_wdata;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [63:0] mdu_wdata;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] mdu_pending;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(
        .XLEN         (64),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wdata  (pipe_wdata),
        .pipe_stall  (pipe_stall),
        .mdu_valid   (mdu_valid),
        .mdu_rd      (mdu_rd),
        .mdu_wdata   (mdu_wdata),
        .mdu_ready   (mdu_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .mdu_pending (mdu_pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  drain_rd   [2];
    logic [63:0] drain_data [2];
    int          got;

    initial begin
        // Reset held with requests active
        reset      = 1'b0;
        pipe_we    = 1'b1;
        pipe_rd    = 5'd5;
        pipe_wdata = 64'hAA;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd7;
        mdu_wdata  = 64'h77;
        tick();
        tick();
        check_eq("rst_rf_we", rf_we, 1'b0);
        check_eq("rst_pending", mdu_pending, 32'h0);
        check_eq("rst_ready", mdu_ready, 1'b1);
        check_eq("rst_waddr", rf_waddr, 5'd0);
        reset     = 1'b1;
        mdu_valid = 1'b0;
        tick();
        check_eq("first_we", rf_we, 1'b1);
        check_eq("first_waddr", rf_waddr, 5'd5);
        check_eq("first_wdata", rf_wdata, 64'hAA);
        pipe_we = 1'b0;
        tick();
        check_eq("idle_we", rf_we, 1'b0);
        check_eq("idle_waddr_hold", rf_waddr, 5'd5);

        // Idle drain
        mdu_valid = 1'b1;
        mdu_rd    = 5'd7;
        mdu_wdata = 64'h1234;
        tick();
        mdu_valid = 1'b0;
        #1;
        check_eq("drain_pend_set", mdu_pending, 32'h80);
        check_eq("drain_we_n1", rf_we, 1'b0);
        tick();
        check_eq("drain_we", rf_we, 1'b1);
        check_eq("drain_waddr", rf_waddr, 5'd7);
        check_eq("drain_wdata", rf_wdata, 64'h1234);
        check_eq("drain_pend_clr", mdu_pending, 32'h0);

        // Starvation
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd3;
        mdu_wdata  = 64'h333;
        pipe_we    = 1'b1;
        pipe_rd    = 5'd10;
        pipe_wdata = 64'h10;
        tick();
        mdu_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pipe_rd    = 5'(11 + k);
            pipe_wdata = 64'(32'h11 + k);
            #1;
            check_eq("starve_stall0", pipe_stall, 1'b0);
            if (k == 0) check_eq("starve_pend", mdu_pending, 32'h8);
            tick();
            check_eq("starve_pipe_waddr", rf_waddr, 64'(11 + k));
        end
        pipe_rd    = 5'd15;
        pipe_wdata = 64'h15;
        #1;
        check_eq("starve_stall1", pipe_stall, 1'b1);
        tick();
        check_eq("forced_we", rf_we, 1'b1);
        check_eq("forced_waddr", rf_waddr, 5'd3);
        check_eq("forced_wdata", rf_wdata, 64'h333);
        check_eq("held_stall0", pipe_stall, 1'b0);
        tick();
        check_eq("held_waddr", rf_waddr, 5'd15);
        check_eq("held_wdata", rf_wdata, 64'h15);
        pipe_we = 1'b0;
        tick();

        // Full / back-pressure
        pipe_we    = 1'b1;
        pipe_rd    = 5'd20;
        pipe_wdata = 64'h20;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd1;
        mdu_wdata  = 64'hD1;
        #1;
        check_eq("full_ready_a", mdu_ready, 1'b1);
        tick();
        mdu_rd    = 5'd2;
        mdu_wdata = 64'hD2;
        #1;
        check_eq("full_ready_b", mdu_ready, 1'b1);
        tick();
        mdu_rd    = 5'd9;
        mdu_wdata = 64'hD9;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("full_ready0", mdu_ready, 1'b0);
            check_eq("full_stall", pipe_stall, (k == 3) ? 1'b1 : 1'b0);
            if (k == 0) check_eq("full_pend", mdu_pending, 32'h6);
            tick();
        end
        check_eq("full_ready_after_pop", mdu_ready, 1'b1);
        check_eq("pop1_waddr", rf_waddr, 5'd1);
        check_eq("pop1_wdata", rf_wdata, 64'hD1);
        tick();
        mdu_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            if (rf_we && rf_waddr != 5'd20) begin
                drain_rd[got]   = rf_waddr;
                drain_data[got] = rf_wdata;
                got++;
            end
            if (got < 2) tick();
        end
        check_eq("drain_count", 64'(got), 64'd2);
        if (got == 2) begin
            check_eq("order_2", drain_rd[0], 5'd2);
            check_eq("order_2_data", drain_data[0], 64'hD2);
            check_eq("order_9", drain_rd[1], 5'd9);
            check_eq("order_9_data", drain_data[1], 64'hD9);
        end
        pipe_we = 1'b0;
        tick();
        tick();
        check_eq("full_empty_pend", mdu_pending, 32'h0);

        // x0 handling
        pipe_we    = 1'b1;
        pipe_rd    = 5'd0;
        pipe_wdata = 64'hBAD;
        #1;
        check_eq("x0_pipe_stall", pipe_stall, 1'b0);
        tick();
        check_eq("x0_pipe_we", rf_we, 1'b0);
        pipe_we   = 1'b0;
        mdu_valid = 1'b1;
        mdu_rd    = 5'd0;
        mdu_wdata = 64'h55;
        tick();
        mdu_valid = 1'b0;
        #1;
        check_eq("x0_mdu_pend", mdu_pending, 32'h0);
        check_eq("x0_mdu_we_n1", rf_we, 1'b0);
        tick();
        check_eq("x0_mdu_we", rf_we, 1'b0);
        check_eq("x0_mdu_waddr", rf_waddr, 5'd0);
        check_eq("x0_mdu_wdata", rf_wdata, 64'h55);
        check_eq("x0_mdu_pend2", mdu_pending, 32'h0);

        // Mid-operation reset
        pipe_we    = 1'b1;
        pipe_rd    = 5'd21;
        pipe_wdata = 64'h21;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd4;
        mdu_wdata  = 64'h44;
        tick();
        mdu_rd    = 5'd6;
        mdu_wdata = 64'h66;
        tick();
        mdu_valid = 1'b0;
        pipe_we   = 1'b0;
        #1;
        check_eq("mid_pend_before", mdu_pending, 32'h50);
        reset = 1'b0;
        #1;
        check_eq("mid_pend_rst", mdu_pending, 32'h0);
        check_eq("mid_we_rst", rf_we, 1'b0);
        check_eq("mid_ready_rst", mdu_ready, 1'b1);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("mid_no_we", rf_we, 1'b0);
            check_eq("mid_no_pend", mdu_pending, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
